case_9_mul_rr_arbiter: RTL and testbench

Shares one combinational signed multiplier (2-bit x 2-bit -> 4-bit, zero pipeline stages) between NUM_REQ independent requesters. Each requester uses a valid/ready handshake. A round-robin arbiter grants at most one request per cycle. The product is registered into a single shared response channel, tagged with the requester index, and held until the consumer accepts it. The block sits between the per-loop operand producers and the downstream accumulate logic of case_9.

---
 rtl/case_9_mul_rr_arbiter.sv | 100 ++++++++++
 tb/tb_case_9_mul_rr_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/case_9_mul_rr_arbiter.sv
// Round-robin arbitrated access to one shared signed multiplier.
// NUM_REQ valid/ready requesters compete for a single registered response slot.
// The response holds its product and requester id until the consumer takes it.
module case_9_mul_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DIN0_WIDTH = 2,
  parameter int DIN1_WIDTH = 2,
  parameter int DOUT_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_b,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DOUT_WIDTH-1:0]          rsp_data,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [CNT_WIDTH-1:0]           op_count
);

  logic                         can_accept;
  logic [ID_WIDTH-1:0]          rr_ptr;
  logic [ID_WIDTH-1:0]          win_id;
  logic [NUM_REQ-1:0]           win_oh;
  logic                         win_found;
  logic                         xfer;
  logic signed [DIN0_WIDTH-1:0] a_sel;
  logic signed [DIN1_WIDTH-1:0] b_sel;
  logic signed [DOUT_WIDTH-1:0] a_ext, b_ext, prod;

  // The response slot is free when empty or being drained this cycle.
  assign can_accept = !rsp_valid | rsp_ready;

  // Rotating priority: first scan from rr_ptr upward, then wrap to the low indices.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_oh    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (i >= int'(rr_ptr))) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_oh[i] = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_found && req_valid[i] && (i < int'(rr_ptr))) begin
        win_found = 1'b1;
        win_id    = ID_WIDTH'(i);
        win_oh[i] = 1'b1;
      end
    end
  end

  // Grant is held off during reset and while the response is back-pressured.
  assign req_ready = win_oh & {NUM_REQ{can_accept & ~ap_rst}};
  assign xfer      = |(req_valid & req_ready);

  // Operand mux from the winner, then one full-precision signed multiply.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        a_sel = req_a[i*DIN0_WIDTH +: DIN0_WIDTH];
        b_sel = req_b[i*DIN1_WIDTH +: DIN1_WIDTH];
      end
    end
    a_ext = DOUT_WIDTH'(a_sel);
    b_ext = DOUT_WIDTH'(b_sel);
    prod  = a_ext * b_ext;
  end

  // Response slot, round-robin pointer and accepted-response counter.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
      op_count  <= '0;
    end else begin
      if (xfer) begin
        rsp_valid <= 1'b1;
        rsp_data  <= prod;
        rsp_id    <= win_id;
        rr_ptr    <= (win_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : win_id + 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (rsp_valid && rsp_ready)
        op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_case_9_mul_rr_arbiter.sv
// Directed bench: table of single-cycle vectors plus hand sequences for
// back-pressure, pointer skip, reset mid-transaction and counter wrap.
module tb_case_9_mul_rr_arbiter;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [3:0]  req_valid, req_ready;
  logic [7:0]  req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [3:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic [15:0] op_count;

  // Narrow-counter instance used only for the wrap check.
  logic        w_rst;
  logic [3:0]  w_valid, w_rdy;
  logic        w_rsp_valid, w_rsp_ready;
  logic [3:0]  w_data;
  logic [1:0]  w_id;
  logic [1:0]  w_cnt;

  int errs = 0;
  int checks = 0;

  always #5 ap_clk = ~ap_clk;

  case_9_mul_rr_arbiter #(.NUM_REQ(4), .ID_WIDTH(2), .DIN0_WIDTH(2), .DIN1_WIDTH(2),
                          .DOUT_WIDTH(4), .CNT_WIDTH(16)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .op_count(op_count));

  case_9_mul_rr_arbiter #(.NUM_REQ(4), .ID_WIDTH(2), .DIN0_WIDTH(2), .DIN1_WIDTH(2),
                          .DOUT_WIDTH(4), .CNT_WIDTH(2)) dut_w (
    .ap_clk(ap_clk), .ap_rst(w_rst), .req_valid(w_valid), .req_ready(w_rdy),
    .req_a(8'h55), .req_b(8'h55), .rsp_valid(w_rsp_valid), .rsp_ready(w_rsp_ready),
    .rsp_data(w_data), .rsp_id(w_id), .op_count(w_cnt));

  typedef struct {
    logic [3:0]  v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        rr;
    logic [3:0]  rdy;
    logic        rv;
    logic [3:0]  d;
    logic [1:0]  id;
    logic [15:0] oc;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic chk_rsp(input string name, input logic rv, input logic [3:0] d, input logic [1:0] id);
    chk({name, ".rsp_valid"}, int'(rsp_valid), int'(rv));
    chk({name, ".rsp_data"},  int'(rsp_data),  int'(d));
    chk({name, ".rsp_id"},    int'(rsp_id),    int'(id));
  endtask

  initial begin
    // Single requests, then sign coverage, then a saturated all-valid stream.
    tbl[0]  = '{4'b0001, 8'b00_00_00_10, 8'b00_00_00_10, 1'b1, 4'b0001, 1'b1, 4'b0100, 2'd0, 16'd0};
    tbl[1]  = '{4'b0000, 8'h00,          8'h00,          1'b1, 4'b0000, 1'b0, 4'b0100, 2'd0, 16'd1};
    tbl[2]  = '{4'b0010, 8'b00_00_10_00, 8'b00_00_01_00, 1'b1, 4'b0010, 1'b1, 4'b1110, 2'd1, 16'd1};
    tbl[3]  = '{4'b0100, 8'b00_01_00_00, 8'b00_11_00_00, 1'b1, 4'b0100, 1'b1, 4'b1111, 2'd2, 16'd2};
    tbl[4]  = '{4'b1000, 8'b11_00_00_00, 8'b11_00_00_00, 1'b1, 4'b1000, 1'b1, 4'b0001, 2'd3, 16'd3};
    tbl[5]  = '{4'b1000, 8'b00_00_00_00, 8'b10_00_00_00, 1'b1, 4'b1000, 1'b1, 4'b0000, 2'd3, 16'd4};
    for (int k = 0; k < 8; k++) begin
      tbl[6+k].v   = 4'b1111;
      tbl[6+k].a   = 8'b11_01_10_01;
      tbl[6+k].b   = 8'b10_11_01_01;
      tbl[6+k].rr  = 1'b1;
      tbl[6+k].id  = 2'(k % 4);
      tbl[6+k].oc  = 16'(5 + k);
      tbl[6+k].rv  = 1'b1;
      case (k % 4)
        0: begin tbl[6+k].rdy = 4'b0001; tbl[6+k].d = 4'b0001; end
        1: begin tbl[6+k].rdy = 4'b0010; tbl[6+k].d = 4'b1110; end
        2: begin tbl[6+k].rdy = 4'b0100; tbl[6+k].d = 4'b1111; end
        default: begin tbl[6+k].rdy = 4'b1000; tbl[6+k].d = 4'b0010; end
      endcase
    end
    tbl[14] = '{4'b0000, 8'h00, 8'h00, 1'b1, 4'b0000, 1'b0, 4'b0010, 2'd3, 16'd13};

    ap_rst = 1'b1; req_valid = 4'b1111; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    w_rst = 1'b1; w_valid = '0; w_rsp_ready = 1'b0;
    cyc();
    cyc();
    chk("reset.req_ready", int'(req_ready), 0);
    chk_rsp("reset", 1'b0, 4'd0, 2'd0);
    chk("reset.op_count", int'(op_count), 0);
    ap_rst = 1'b0; req_valid = '0;

    for (int n = 0; n < 15; n++) begin
      req_valid = tbl[n].v; req_a = tbl[n].a; req_b = tbl[n].b; rsp_ready = tbl[n].rr;
      #1;
      chk($sformatf("vec%0d.req_ready", n), int'(req_ready), int'(tbl[n].rdy));
      cyc();
      chk_rsp($sformatf("vec%0d", n), tbl[n].rv, tbl[n].d, tbl[n].id);
      chk($sformatf("vec%0d.op_count", n), int'(op_count), int'(tbl[n].oc));
    end

    // Back-pressure: hold a response from requester 0, rr_ptr moves to 1.
    rsp_ready = 1'b0; req_valid = 4'b0001; req_a = 8'b00_00_00_01; req_b = 8'b00_00_00_01;
    #1 chk("bp.load.req_ready", int'(req_ready), 4'b0001);
    cyc();
    chk_rsp("bp.load", 1'b1, 4'b0001, 2'd0);
    req_valid = 4'b0110; req_a = 8'b00_11_10_00; req_b = 8'b00_01_10_00;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("bp.hold%0d.req_ready", k), int'(req_ready), 0);
      cyc();
      chk_rsp($sformatf("bp.hold%0d", k), 1'b1, 4'b0001, 2'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp.release.req_ready", int'(req_ready), 4'b0010);
    cyc();
    chk_rsp("bp.release", 1'b1, 4'b0100, 2'd1);
    req_valid = 4'b0100;
    #1 chk("bp.next.req_ready", int'(req_ready), 4'b0100);
    cyc();
    chk_rsp("bp.next", 1'b1, 4'b1111, 2'd2);
    req_valid = 4'b0000;
    cyc();
    chk("bp.drain.rsp_valid", int'(rsp_valid), 0);

    // Pointer skip: get rr_ptr to 2, then only requesters 0 and 3 valid.
    req_valid = 4'b0010; req_a = 8'b00_00_10_00; req_b = 8'b00_00_10_00;
    #1 chk("skip.prep.req_ready", int'(req_ready), 4'b0010);
    cyc();
    req_valid = 4'b1001; req_a = 8'b01_00_00_10; req_b = 8'b11_00_00_01;
    #1 chk("skip.first.req_ready", int'(req_ready), 4'b1000);
    cyc();
    chk_rsp("skip.first", 1'b1, 4'b1111, 2'd3);
    req_valid = 4'b0001;
    #1 chk("skip.second.req_ready", int'(req_ready), 4'b0001);
    cyc();
    chk_rsp("skip.second", 1'b1, 4'b1110, 2'd0);
    req_valid = 4'b1111;
    #1 chk("skip.ptr_is_1", int'(req_ready), 4'b0010);
    cyc();

    // Reset while a response is held under back-pressure.
    req_valid = 4'b0000; rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0; req_valid = 4'b0001; req_a = 8'b00_00_00_01; req_b = 8'b00_00_00_01;
    cyc();
    chk_rsp("rst.pending", 1'b1, 4'b0001, 2'd0);
    ap_rst = 1'b1; req_valid = 4'b1111;
    #1 chk("rst.req_ready.bp", int'(req_ready), 0);
    rsp_ready = 1'b1;
    #1 chk("rst.req_ready.free", int'(req_ready), 0);
    cyc();
    chk_rsp("rst.after", 1'b0, 4'd0, 2'd0);
    chk("rst.op_count", int'(op_count), 0);
    ap_rst = 1'b0;
    #1 chk("rst.ptr_is_0", int'(req_ready), 4'b0001);
    cyc();
    req_valid = 4'b0000;

    // Counter wrap on the 2-bit instance: one accept per cycle after the first transfer.
    cyc();
    w_rst = 1'b0; w_valid = 4'b0001; w_rsp_ready = 1'b1;
    cyc();
    chk("wrap.first", int'(w_cnt), 0);
    for (int k = 0; k < 3; k++) cyc();
    chk("wrap.max", int'(w_cnt), 3);
    cyc();
    chk("wrap.zero", int'(w_cnt), 0);
    w_valid = '0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
